// File: rtl/packet_deserializer.sv
// packet_deserializer
// Collects a stream of IN_W-bit words (valid/ready/last) into one OUT_W-bit
// record, MSB-first, and presents it on a valid/ready output register.
// Packets with the wrong word count are dropped and counted; a completed
// packet arriving while the output is still held either stalls the input
// (DROP_ON_FULL=0) or is dropped (DROP_ON_FULL=1).
module packet_deserializer #(
  parameter int IN_W         = 32,
  parameter int OUT_W        = 296,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   dataIn,
  input  logic              dataInVal,
  output logic              dataInReady,
  input  logic              dataInLast,
  output logic [0:OUT_W-1]  dataOut,
  output logic              dataOutVal,
  input  logic              dataOutReady,
  output logic              packetLost,
  output logic [CNT_W-1:0]  lostCount
);

  localparam int WORDS    = (OUT_W + IN_W - 1) / IN_W;
  localparam int LAST_W   = OUT_W - (WORDS - 1) * IN_W;  // bits used from the final word
  localparam int ACC_W    = (WORDS - 1) * IN_W;          // bits held before the final word
  localparam int CNT_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(WORDS - 1);

  typedef enum logic {
    ST_ACCUM,
    ST_DISCARD
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_next;
  logic [0:ACC_W-1]    r_acc;
  logic [0:OUT_W-1]    r_data_out;
  logic                r_out_val;
  logic                r_lost;
  logic [CNT_W-1:0]    r_lost_cnt;

  logic                w_full;
  logic                w_at_last;
  logic                w_in_ready;
  logic                w_beat;
  logic                w_complete;
  logic                w_drop;
  logic [0:OUT_W-1]    w_record;

  // Input handshake: only the final word of a packet can be stalled by a held record.
  always_comb begin
    w_full    = r_out_val && !dataOutReady;
    w_at_last = (r_state == ST_ACCUM) && (r_cnt == LAST_IDX);
    if (reset) begin
      w_in_ready = 1'b0;
    end else if (DROP_ON_FULL != 0) begin
      w_in_ready = 1'b1;
    end else begin
      w_in_ready = !(w_at_last && w_full);
    end
    w_beat = dataInVal && w_in_ready;
  end

  assign dataInReady = w_in_ready;

  // Record is the buffered words followed by the top LAST_W bits of the final word.
  assign w_record = {r_acc, dataIn[IN_W-1 -: LAST_W]};

  // Next-state, word counter and per-beat completion/drop decisions.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_complete   = 1'b0;
    w_drop       = 1'b0;
    if (w_beat) begin
      case (r_state)
        ST_ACCUM: begin
          if (dataInLast) begin
            w_cnt_next = '0;
            if (r_cnt == LAST_IDX) begin
              // Only reachable while full when the input never stalls.
              if (w_full) w_drop = 1'b1;
              else        w_complete = 1'b1;
            end else begin
              w_drop = 1'b1;  // short packet
            end
          end else if (r_cnt == LAST_IDX) begin
            w_state_next = ST_DISCARD;  // long packet: swallow until last
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_DISCARD: begin
          if (dataInLast) begin
            w_state_next = ST_ACCUM;
            w_drop       = 1'b1;
          end
        end
      endcase
    end
  end

  // State and word counter registers.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Word buffer: each accepted word lands at its slot, first bit at the lowest index.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath storage is not reset; a stale slot is always
    // overwritten before a record can be built from it.
    if (w_beat && (r_state == ST_ACCUM)) begin
      for (int k = 0; k < WORDS - 1; k++) begin
        if (r_cnt == CNT_BITS'(k)) r_acc[k*IN_W +: IN_W] <= dataIn;
      end
    end
  end

  // Output register: a load wins over a pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_val  <= 1'b0;
      r_data_out <= '0;
    end else if (w_complete) begin
      r_out_val  <= 1'b1;
      r_data_out <= w_record;
    end else if (dataOutReady) begin
      r_out_val  <= 1'b0;
    end
  end

  // Drop pulse and saturating drop counter, both updated on the deciding edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lost     <= 1'b0;
      r_lost_cnt <= '0;
    end else begin
      r_lost <= w_drop;
      if (w_drop && (r_lost_cnt != '1)) r_lost_cnt <= r_lost_cnt + 1'b1;
    end
  end

  assign dataOut    = r_data_out;
  assign dataOutVal = r_out_val;
  assign packetLost = r_lost;
  assign lostCount  = r_lost_cnt;

endmodule

// File: tb/tb_packet_deserializer.sv
// Bench for packet_deserializer: two instances share the clock.
// dut0: DROP_ON_FULL=0, CNT_W=16. dut1: DROP_ON_FULL=1, CNT_W=2.
// Expected records are queued when a packet is issued; a negedge monitor
// pops and compares whenever a record is handed off.
module tb_packet_deserializer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 296;
  localparam int WORDS = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      dval;
  logic [1:0]      dlast;
  logic [1:0]      ordy;
  logic [IN_W-1:0] din [2];

  wire  [1:0]       irdy;
  wire  [1:0]       oval;
  wire  [1:0]       plost;
  wire  [0:OUT_W-1] dout0;
  wire  [0:OUT_W-1] dout1;
  wire  [15:0]      lc0;
  wire  [1:0]       lc1;

  packet_deserializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DROP_ON_FULL(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst[0]), .dataIn(din[0]), .dataInVal(dval[0]),
    .dataInReady(irdy[0]), .dataInLast(dlast[0]), .dataOut(dout0),
    .dataOutVal(oval[0]), .dataOutReady(ordy[0]), .packetLost(plost[0]),
    .lostCount(lc0)
  );

  packet_deserializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DROP_ON_FULL(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(rst[1]), .dataIn(din[1]), .dataInVal(dval[1]),
    .dataInReady(irdy[1]), .dataInLast(dlast[1]), .dataOut(dout1),
    .dataOutVal(oval[1]), .dataOutReady(ordy[1]), .packetLost(plost[1]),
    .lostCount(lc1)
  );

  int checks = 0;
  int errors = 0;

  logic [0:OUT_W-1] q0 [$];
  logic [0:OUT_W-1] q1 [$];
  logic [0:OUT_W-1] last_out [2];
  logic [0:OUT_W-1] prev_out [2];
  logic [0:OUT_W-1] mon_cur;
  logic [0:OUT_W-1] mon_exp;
  bit               held [2];
  int               seen_pulses [2];
  int               exp_pulses [2];
  int               exp_cnt [2];

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] word_of(input int pat, input int k);
    if (pat == 0) return 32'(k + 1) << 24;
    return 32'h1357_9BDF * 32'(pat) + 32'h0F1E_2D3C * 32'(k + 1);
  endfunction

  // Word k, bit 31-j lands at record bit k*32+j; bits past OUT_W are ignored.
  function automatic logic [0:OUT_W-1] rec_of(input int pat);
    logic [0:OUT_W-1] r;
    logic [IN_W-1:0]  w;
    r = '0;
    for (int k = 0; k < WORDS; k++) begin
      w = word_of(pat, k);
      for (int j = 0; j < IN_W; j++)
        if (k*IN_W + j < OUT_W) r[k*IN_W + j] = w[IN_W-1-j];
    end
    return r;
  endfunction

  function automatic int get_lc(input int i);
    return (i == 0) ? int'(lc0) : int'(lc1);
  endfunction

  task automatic note_drop(input int i);
    int max_cnt;
    max_cnt = (i == 0) ? 65535 : 3;
    exp_pulses[i]++;
    if (exp_cnt[i] < max_cnt) exp_cnt[i]++;
  endtask

  // Monitor: hold stability, record handoff against the scoreboard, pulse count.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mon_cur = (i == 0) ? dout0 : dout1;
      if (held[i]) begin
        check("hold_valid", OUT_W'(oval[i]), OUT_W'(1));
        check("hold_data", mon_cur, prev_out[i]);
      end
      if (oval[i] && ordy[i]) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record dut%0d: got %0h expected none", i, mon_cur);
        end else begin
          mon_exp = (i == 0) ? q0.pop_front() : q1.pop_front();
          check("record", mon_cur, mon_exp);
        end
        last_out[i] = mon_cur;
      end
      held[i]     = oval[i] && !ordy[i];
      prev_out[i] = mon_cur;
      if (plost[i]) seen_pulses[i]++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One beat; first_rdy >= 0 checks dataInReady on the first attempt.
  task automatic send_word(input int i, input logic [IN_W-1:0] w, input bit last, input int first_rdy);
    int n;
    bit done;
    din[i] = w; dlast[i] = last; dval[i] = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (n == 0 && first_rdy >= 0) check("in_ready_first", OUT_W'(irdy[i]), OUT_W'(first_rdy));
      if (irdy[i]) done = 1'b1;
      next_cycle();
      n++;
    end
    dval[i] = 1'b0; dlast[i] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout dut%0d: got ready=0 for 200 cycles expected ready=1", i);
    end
  endtask

  task automatic send_packet(input int i, input int n, input int pat, input int last_rdy);
    for (int k = 0; k < n; k++)
      send_word(i, word_of(pat, k), k == n - 1, (k == n - 1) ? last_rdy : -1);
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1; dval[i] = 1'b0; dlast[i] = 1'b0;
    @(negedge clk);
    check("ready_in_reset", OUT_W'(irdy[i]), OUT_W'(0));
    next_cycle();
    next_cycle();
    rst[i] = 1'b0;
    exp_cnt[i] = 0;
    @(negedge clk);
    check("rst_out_val", OUT_W'(oval[i]), OUT_W'(0));
    check("rst_out_data", (i == 0) ? dout0 : dout1, '0);
    check("rst_lost", OUT_W'(plost[i]), OUT_W'(0));
    check("rst_count", OUT_W'(get_lc(i)), OUT_W'(0));
    check("rst_ready", OUT_W'(irdy[i]), OUT_W'(1));
    next_cycle();
  endtask

  task automatic drain();
    repeat (4) next_cycle();
  endtask

  logic [7:0] byte_v;
  logic [0:OUT_W-1] rec_v;
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 2'b11; dval = '0; dlast = '0; ordy = 2'b11;
    din[0] = '0; din[1] = '0;
    for (int i = 0; i < 2; i++) begin
      seen_pulses[i] = 0; exp_pulses[i] = 0; exp_cnt[i] = 0; held[i] = 1'b0;
    end
    do_reset(0);
    do_reset(1);

    // Good packet with k+1 in the top byte.
    q0.push_back(rec_of(0));
    send_packet(0, 10, 0, -1);
    drain();
    check("good_popped", OUT_W'(q0.size()), OUT_W'(0));
    rec_v = last_out[0];
    byte_v = rec_v[0:7];
    check("good_first_byte", OUT_W'(byte_v), OUT_W'(8'h01));
    byte_v = rec_v[288:295];
    check("good_last_byte", OUT_W'(byte_v), OUT_W'(8'h0A));
    check("good_no_loss", OUT_W'(seen_pulses[0]), OUT_W'(0));

    // Short packet, then a good one.
    send_packet(0, 4, 1, -1);
    note_drop(0);
    @(negedge clk);
    check("short_pulse", OUT_W'(plost[0]), OUT_W'(1));
    check("short_count", OUT_W'(lc0), OUT_W'(1));
    next_cycle();
    @(negedge clk);
    check("short_pulse_end", OUT_W'(plost[0]), OUT_W'(0));
    next_cycle();
    q0.push_back(rec_of(2));
    send_packet(0, 10, 2, -1);
    drain();
    check("short_then_good", OUT_W'(q0.size()), OUT_W'(0));
    check("short_pulses", OUT_W'(seen_pulses[0]), OUT_W'(exp_pulses[0]));

    // Long packet: 13 beats, single drop, no record; then a good one.
    do_reset(0);
    send_packet(0, 13, 6, -1);
    note_drop(0);
    @(negedge clk);
    check("long_pulse", OUT_W'(plost[0]), OUT_W'(1));
    check("long_count", OUT_W'(lc0), OUT_W'(1));
    check("long_no_valid", OUT_W'(oval[0]), OUT_W'(0));
    next_cycle();
    q0.push_back(rec_of(7));
    send_packet(0, 10, 7, -1);
    drain();
    check("long_then_good", OUT_W'(q0.size()), OUT_W'(0));
    check("long_pulses", OUT_W'(seen_pulses[0]), OUT_W'(exp_pulses[0]));

    // Reset after 5 beats: partial data dropped silently.
    for (int k = 0; k < 5; k++) send_word(0, word_of(8, k), 1'b0, -1);
    do_reset(0);
    q0.push_back(rec_of(9));
    send_packet(0, 10, 9, -1);
    drain();
    check("reset_then_good", OUT_W'(q0.size()), OUT_W'(0));
    check("reset_count", OUT_W'(lc0), OUT_W'(0));
    check("reset_pulses", OUT_W'(seen_pulses[0]), OUT_W'(exp_pulses[0]));

    // Backpressure: second packet's last beat stalls until the output pops.
    ordy[0] = 1'b0;
    q0.push_back(rec_of(3));
    q0.push_back(rec_of(4));
    send_packet(0, 10, 3, -1);
    for (int k = 0; k < 9; k++) send_word(0, word_of(4, k), 1'b0, -1);
    fork
      send_word(0, word_of(4, 9), 1'b1, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_ready", OUT_W'(irdy[0]), OUT_W'(0));
        end
        @(posedge clk);
        #2;
        ordy[0] = 1'b1;
      end
    join
    @(negedge clk);
    check("bp_valid_stays", OUT_W'(oval[0]), OUT_W'(1));
    next_cycle();
    drain();
    check("bp_both_popped", OUT_W'(q0.size()), OUT_W'(0));
    check("bp_no_loss", OUT_W'(seen_pulses[0]), OUT_W'(exp_pulses[0]));

    // Full-drop policy: input never stalls, second packet dropped.
    ordy[1] = 1'b0;
    q1.push_back(rec_of(10));
    send_packet(1, 10, 10, -1);
    for (int k = 0; k < 9; k++) send_word(1, word_of(11, k), 1'b0, -1);
    send_word(1, word_of(11, 9), 1'b1, 1);
    note_drop(1);
    @(negedge clk);
    check("fd_pulse", OUT_W'(plost[1]), OUT_W'(1));
    check("fd_count", OUT_W'(lc1), OUT_W'(1));
    check("fd_valid", OUT_W'(oval[1]), OUT_W'(1));
    check("fd_held_record", dout1, rec_of(10));
    next_cycle();
    ordy[1] = 1'b1;
    drain();
    check("fd_popped", OUT_W'(q1.size()), OUT_W'(0));

    // Saturation of the 2-bit counter.
    do_reset(1);
    for (int p = 0; p < 5; p++) begin
      send_packet(1, 3, 12 + p, -1);
      note_drop(1);
      @(negedge clk);
      check("sat_count", OUT_W'(lc1), OUT_W'(sat_exp[p]));
      next_cycle();
    end
    drain();
    check("sat_pulses", OUT_W'(seen_pulses[1]), OUT_W'(exp_pulses[1]));
    check("final_q0", OUT_W'(q0.size()), OUT_W'(0));
    check("final_q1", OUT_W'(q1.size()), OUT_W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/packet_deserializer.md
Name: packet_deserializer

Overview:
- Parametrised next-generation sequence parser.
- Collects a stream of IN_W-bit words (valid/ready/last) into one OUT_W-bit record and presents it on a valid/ready output register.
- Drops malformed packets (short or long) and reports every drop on packetLost and a saturating lost counter.
- Selectable full-output policy: backpressure or drop.

Parameters:
- IN_W, 32, input word width in bits.
- OUT_W, 296, record width in bits. WORDS = ceil(OUT_W/IN_W) is a derived localparam (10 at defaults).
- DROP_ON_FULL, 0, 0 = stall input when the output register is full; 1 = never stall, drop the completed packet instead.
- CNT_W, 16, width of the lost-packet counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  IN_W  input word.
- dataInVal  in  1  dataIn valid.
- dataInReady  out  1  block can accept a word.
- dataInLast  in  1  current word ends the packet.
- dataOut  out  [0:OUT_W-1]  assembled record; bit 0 is the first received bit.
- dataOutVal  out  1  dataOut holds a valid record.
- dataOutReady  in  1  downstream accepts the record.
- packetLost  out  1  one-cycle pulse per dropped packet.
- lostCount  out  CNT_W  saturating count of dropped packets.

Behaviour:
- Beat: a word is accepted on a rising edge where dataInVal && dataInReady.
- Packing, MSB-first:
  - Word k (k = 0..WORDS-1), bit IN_W-1-j, maps to dataOut[k*IN_W + j].
  - For the final word, only its upper OUT_W-(WORDS-1)*IN_W bits are used (8 bits, dataIn[31:24], at defaults); the rest are ignored.
- State machine, word counter cnt in 0..WORDS-1:
  - ACCUM, beat with last and cnt==WORDS-1: packet complete. Load the record into the output register, cnt to 0.
  - ACCUM, beat with last and cnt<WORDS-1: short packet. Drop it, cnt to 0.
  - ACCUM, beat without last and cnt==WORDS-1: long packet. Go to DISCARD, cnt to 0.
  - ACCUM, other beats: cnt increments.
  - DISCARD: accept and ignore beats. On a beat with last: drop, return to ACCUM.
- Output register:
  - On completion: dataOutVal goes to 1 the next cycle with the new record.
  - dataOutVal clears after a cycle with dataOutVal && dataOutReady, unless a completion happens in that same cycle; then the new record loads and dataOutVal stays 1.
  - dataOut is stable while dataOutVal && !dataOutReady.
- dataInReady:
  - 0 whenever reset is high.
  - DROP_ON_FULL=0: dataInReady = !(ACCUM && cnt==WORDS-1 && dataOutVal && !dataOutReady). This is combinational from dataOutReady; no stall happens at any other position.
  - DROP_ON_FULL=1: 1 whenever reset is low. A completion while dataOutVal && !dataOutReady counts as a drop; the held record is kept unchanged.
- Drops (short, long, or full-drop):
  - packetLost is high for exactly one cycle, the cycle after the beat that decides the drop.
  - lostCount increments in that same cycle and saturates at 2^CNT_W-1.
  - No output change occurs on a drop.
- Reset values: dataOutVal=0, dataOut=0, packetLost=0, lostCount=0, state ACCUM, cnt=0. Reset mid-packet or mid-discard discards the partial data and does not count it as a drop.
- Latency: the last beat is accepted at edge N; dataOutVal is high after edge N (visible in cycle N+1).
- Idle cycles (dataInVal=0) in the middle of a packet are allowed and have no effect.

Test Plan:
- Good packet: 10 beats with words 0x01000000..0x0A000000 (k+1 in the top byte), last on beat 10, dataOutReady=1. Required: dataOutVal high for 1 cycle; dataOut[0:7]=0x01, dataOut[288:295]=0x0A; packetLost never high.
- Short packet: 4 beats, last on beat 4, then a good packet. Required: packetLost pulses once after beat 4; lostCount=1; the following good packet is output correctly.
- Long packet: 13 beats, last on beat 13. Required: DISCARD entered after beat 10; a single packetLost pulse after beat 13; lostCount=1; dataOutVal stays 0.
- Backpressure (DROP_ON_FULL=0): dataOutReady=0, two back-to-back good packets. Required: dataInReady=0 at beat 10 of packet 2 until dataOutReady=1. Then record 1 pops and record 2 loads in the same cycle, dataOutVal stays 1, and no loss is reported.
- Full-drop (DROP_ON_FULL=1): same stimulus as backpressure. Required: dataInReady stays 1; packet 2 is dropped; lostCount=1; dataOut still holds record 1.
- Reset and saturation:
  - Assert reset after 5 beats: dataInReady=0 during reset; the next packet is assembled from word 0; lostCount stays 0.
  - With CNT_W=2, send 5 short packets: lostCount goes 1,2,3,3,3.
